rank_filter: RTL and testbench
==============================

Name: rank_filter

Overview:
- Parametrised successor to the 9-sample byte median block.
- Collects a frame of N samples, one per clock while DSI is high, and returns the sample of a run-time selectable rank (default median).
- Also returns the frame min and max.
- Sorts on the fly with a systolic insertion array, so the result is available one cycle after the last sample, with no post-frame sort phase.
- Sits in the pixel/sample filtering path, drop-in for the fixed median block when N=9, WIDTH=8, RANK=4.

Parameters:
- WIDTH, 8: sample width in bits.
- N, 9: samples per frame; odd, 3..31.
- SIGNED, 0: 0 = unsigned compare, 1 = two's-complement compare.
- RW, $clog2(N): width of the RANK port.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- DSI  in  1  data strobe in; DI is valid on every rising edge where DSI=1.
- DI  in  WIDTH  input sample.
- RANK  in  RW  requested rank, 0 = smallest; sampled with the first sample of each frame.
- DO  out  WIDTH  selected-rank sample of the last complete frame.
- DMIN  out  WIDTH  minimum of the last complete frame.
- DMAX  out  WIDTH  maximum of the last complete frame.
- DSO  out  1  one-cycle pulse: DO/DMIN/DMAX are valid and updated.
- ERR  out  1  one-cycle pulse: frame aborted (DSI fell before N samples).

Behaviour:
- Reset (async, nRST=0):
  - DO, DMIN, DMAX = 0; DSO = 0; ERR = 0.
  - Sample count = 0; sorted array contents are don't-care and are marked empty.
- Storage:
  - Sorted array S[0..N-1] (ascending) plus count cnt (0..N).
  - Slots with index >= cnt are treated as empty (+infinity).
- Insertion on each edge with DSI=1:
  - New sample x goes to the first slot i with x < S[i] (or i = cnt).
  - Slots i..cnt-1 shift up by one; cnt increments.
  - Equal values insert after existing equals (stable). Ties are irrelevant to the output value.
  - Comparison is signed when SIGNED=1, unsigned otherwise.
- First sample of a frame (cnt=0):
  - Latch RANK into rank_q; if RANK >= N, clamp to N-1.
  - All slots are treated as empty regardless of contents, so no clear cycle is needed.
- Frame completion:
  - The edge capturing the Nth sample (cnt goes N-1 -> N) is edge t.
  - At edge t+1: DO = S[rank_q], DMIN = S[0], DMAX = S[N-1], DSO = 1, cnt = 0 (unless a new sample is captured at t+1, in which case cnt = 1).
  - DSO = 0 at t+2 unless another frame completes.
  - Latency from last sample to DSO: 1 cycle.
- Back-to-back frames:
  - DSI held high past N samples: sample N+1 starts a new frame at edge t+1, in the same cycle the result of the previous frame is registered.
  - The result is taken from the pre-edge array, so no sample is lost or mixed.
  - Sustained throughput: one frame per N cycles.
- Abort:
  - DSI=0 at an edge with 0 < cnt < N: cnt = 0, ERR = 1 for one cycle, no DSO.
  - DO/DMIN/DMAX keep their previous values.
- Idle: DSI=0 with cnt=0 produces no pulses; outputs hold.
- DI is ignored when DSI=0.
- Reset mid-frame discards the partial frame with no DSO or ERR pulse.
- DO/DMIN/DMAX change only in a cycle where DSO=1.
- Implementation: one insertion per cycle, built from N parallel comparators and muxes; no multicycle paths.

Test Plan:
- Median: N=9, WIDTH=8, RANK=4, DI = 12,200,7,99,45,45,3,250,128 -> DSO one cycle after the 9th sample; DO=45, DMIN=3, DMAX=250; DSO high exactly 1 cycle.
- Rank select: same data with RANK=0 -> DO=3; RANK=8 -> DO=250; RANK=15 (clamped) -> DO=250. RANK changed mid-frame from 4 to 0 -> DO=45.
- Back-to-back: two frames with DSI held high for 18 cycles; frame 2 = 9 x 17 -> two DSO pulses 9 cycles apart, DO=45 then DO=17.
- Abort: DSI high for 5 samples then low -> ERR pulse 1 cycle, no DSO, DO unchanged. Next full frame completes normally.
- Signed: SIGNED=1, DI = -128,127,-1,1,0,2,-2,5,-5 (8-bit) -> DO=0x00, DMIN=0x80, DMAX=0x7F.
- Random plus reset: 1000 random 9-sample frames with a software sort reference -> DO equals the reference median every frame. nRST pulsed mid-frame -> all outputs 0, no pulse; next frame correct.

Source files
------------

// File: rtl/rank_filter.sv
// rank_filter: collects a frame of N samples (one per clock while DSI is
// high) and reports the sample of a run-time selected rank plus the frame
// minimum and maximum. Samples are sorted on the fly by an insertion array,
// so the result is registered one cycle after the last sample.
//
// Ports:
//   CLK   in        rising-edge clock
//   nRST  in        asynchronous active-low reset
//   DSI   in        data strobe; DI is captured on every rising edge with DSI=1
//   DI    in  W     input sample
//   RANK  in  RW    requested rank (0 = smallest), sampled with the first sample
//   DO    out W     selected-rank sample of the last complete frame
//   DMIN  out W     minimum of the last complete frame
//   DMAX  out W     maximum of the last complete frame
//   DSO   out 1     one-cycle pulse: DO/DMIN/DMAX were just updated
//   ERR   out 1     one-cycle pulse: frame aborted (DSI fell before N samples)
//
// Handshake: DSI is a pure strobe with no back-pressure; every edge with
// DSI=1 consumes DI, and DSO/ERR are single-cycle pulses with no ready.

module rank_filter #(
    parameter int WIDTH  = 8,
    parameter int N      = 9,
    parameter int SIGNED = 0,
    parameter int RW     = $clog2(N)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             DSI,
    input  logic [WIDTH-1:0] DI,
    input  logic [RW-1:0]    RANK,
    output logic [WIDTH-1:0] DO,
    output logic [WIDTH-1:0] DMIN,
    output logic [WIDTH-1:0] DMAX,
    output logic             DSO,
    output logic             ERR
);

    localparam int CW = $clog2(N + 1);

    logic [WIDTH-1:0] s_q [N];
    logic [WIDTH-1:0] s_d [N];
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    base;
    logic [RW-1:0]    rank_q, rank_d;
    logic [RW-1:0]    rank_clamped;
    logic [N-1:0]     gt;
    logic             frame_full;
    logic             abort;

    function automatic logic less_than(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
        if (SIGNED != 0) return $signed(a) < $signed(b);
        else             return a < b;
    endfunction

    always_comb begin
        frame_full = (cnt_q == CW'(N));
        // A full array is being read out this cycle, so a new sample starts
        // from an empty array; the readout uses the pre-edge contents.
        base  = frame_full ? '0 : cnt_q;
        abort = !DSI && (cnt_q != '0) && !frame_full;

        // gt[i]: the new sample belongs at or below slot i. Empty slots act as
        // +infinity; strict compare keeps equal values in arrival order.
        for (int i = 0; i < N; i++) begin
            gt[i] = (CW'(i) >= base) || less_than(DI, s_q[i]);
        end

        // gt is monotonic over a sorted array: the first set bit takes the
        // new sample, every slot above it shifts up by one.
        s_d[0] = s_q[0];
        if (DSI && gt[0]) s_d[0] = DI;
        for (int i = 1; i < N; i++) begin
            s_d[i] = s_q[i];
            if (DSI && gt[i]) s_d[i] = gt[i-1] ? s_q[i-1] : DI;
        end

        cnt_d = DSI ? base + CW'(1) : '0;

        rank_clamped = ({1'b0, RANK} >= (RW+1)'(N)) ? RW'(N - 1) : RANK;
        rank_d       = (DSI && base == '0) ? rank_clamped : rank_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < N; i++) s_q[i] <= '0;
            cnt_q  <= '0;
            rank_q <= '0;
            DO     <= '0;
            DMIN   <= '0;
            DMAX   <= '0;
            DSO    <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) s_q[i] <= s_d[i];
            cnt_q  <= cnt_d;
            rank_q <= rank_d;
            DSO    <= frame_full;
            ERR    <= abort;
            if (frame_full) begin
                DO   <= s_q[rank_q];
                DMIN <= s_q[0];
                DMAX <= s_q[N-1];
            end
        end
    end

endmodule

// File: tb/tb_rank_filter.sv
// Bench for rank_filter: an unsigned and a signed instance share the same
// stimulus; a sorting reference model predicts both results per frame.

module tb_rank_filter;

    logic       clk;
    logic       rst_n;
    logic       dsi;
    logic [7:0] di;
    logic [3:0] rank;
    logic [7:0] u_do, u_min, u_max, s_do, s_min, s_max;
    logic       u_dso, u_err, s_dso, s_err;

    int n_tests = 0;
    int n_fail  = 0;

    // expected {u_do,u_min,u_max,s_do,s_min,s_max} per frame, in order
    logic [47:0] exp_q[$];
    logic [47:0] last_exp = '0;

    rank_filter #(.WIDTH(8), .N(9), .SIGNED(0)) u_dut (
        .CLK(clk), .nRST(rst_n), .DSI(dsi), .DI(di), .RANK(rank),
        .DO(u_do), .DMIN(u_min), .DMAX(u_max), .DSO(u_dso), .ERR(u_err)
    );

    rank_filter #(.WIDTH(8), .N(9), .SIGNED(1)) s_dut (
        .CLK(clk), .nRST(rst_n), .DSI(dsi), .DI(di), .RANK(rank),
        .DO(s_do), .DMIN(s_min), .DMAX(s_max), .DSO(s_dso), .ERR(s_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [47:0] model(input logic [7:0] f[9], input logic [3:0] r);
        int u[9];
        int s[9];
        int rc;
        int t;
        rc = (r >= 4'd9) ? 8 : int'(r);
        for (int i = 0; i < 9; i++) begin
            u[i] = int'(f[i]);
            s[i] = int'($signed(f[i]));
        end
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8 - a; b++) begin
                if (u[b] > u[b+1]) begin t = u[b]; u[b] = u[b+1]; u[b+1] = t; end
                if (s[b] > s[b+1]) begin t = s[b]; s[b] = s[b+1]; s[b+1] = t; end
            end
        end
        return {u[rc][7:0], u[0][7:0], u[8][7:0], s[rc][7:0], s[0][7:0], s[8][7:0]};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_u_dso"}, 32'(u_dso), 32'd0);
        chk({tag, "_u_err"}, 32'(u_err), 32'd0);
        chk({tag, "_s_dso"}, 32'(s_dso), 32'd0);
        chk({tag, "_s_err"}, 32'(s_err), 32'd0);
    endtask

    // called #1 after the edge where a result should have been registered
    task automatic check_result(input string tag);
        logic [47:0] e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_u_dso"}, 32'(u_dso), 32'd1);
        chk({tag, "_u_err"}, 32'(u_err), 32'd0);
        chk({tag, "_u_do"},  32'(u_do),  32'(e[47:40]));
        chk({tag, "_u_min"}, 32'(u_min), 32'(e[39:32]));
        chk({tag, "_u_max"}, 32'(u_max), 32'(e[31:24]));
        chk({tag, "_s_dso"}, 32'(s_dso), 32'd1);
        chk({tag, "_s_do"},  32'(s_do),  32'(e[23:16]));
        chk({tag, "_s_min"}, 32'(s_min), 32'(e[15:8]));
        chk({tag, "_s_max"}, 32'(s_max), 32'(e[7:0]));
        last_exp = e;
    endtask

    // ---------------- drivers ----------------
    // Drives 9 samples back to back; if a previous frame is pending its
    // result is checked after the first edge (shared with the first sample).
    task automatic send_frame(input logic [7:0] f[9], input logic [3:0] r0,
                              input logic [3:0] r1, input bit check_prev,
                              input string tag);
        exp_q.push_back(model(f, r0));
        for (int i = 0; i < 9; i++) begin
            dsi  = 1'b1;
            di   = f[i];
            rank = (i == 0) ? r0 : r1;
            @(posedge clk); #1;
            if (i == 0 && check_prev) check_result({tag, "_prev"});
            else if (i == 0) chk_idle({tag, "_first"});
        end
    endtask

    // drop DSI after a complete frame and check the pulse and its end
    task automatic finish_frame(input string tag);
        chk_idle({tag, "_pre"});
        dsi = 1'b0;
        di  = 8'($urandom);
        @(posedge clk); #1;
        check_result(tag);
        @(posedge clk); #1;
        chk_idle({tag, "_post"});
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] med_f[9];
    logic [7:0] f17[9];
    logic [7:0] sgn_f[9];
    logic [7:0] rf[9];
    logic [3:0] r0, r1;

    initial begin
        med_f = '{8'd12, 8'd200, 8'd7, 8'd99, 8'd45, 8'd45, 8'd3, 8'd250, 8'd128};
        f17   = '{default: 8'd17};
        sgn_f = '{8'h80, 8'h7F, 8'hFF, 8'h01, 8'h00, 8'h02, 8'hFE, 8'h05, 8'hFB};

        rst_n = 1'b0;
        dsi   = 1'b0;
        di    = '0;
        rank  = '0;
        #1;
        chk("rst_u_do",  32'(u_do),  32'd0);
        chk("rst_u_min", 32'(u_min), 32'd0);
        chk("rst_u_max", 32'(u_max), 32'd0);
        chk_idle("rst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_idle("idle");

        // median
        send_frame(med_f, 4'd4, 4'd4, 1'b0, "med");
        finish_frame("med");
        chk("med_do_const",  32'(u_do),  32'd45);
        chk("med_min_const", 32'(u_min), 32'd3);
        chk("med_max_const", 32'(u_max), 32'd250);

        // rank select and clamp
        send_frame(med_f, 4'd0, 4'd0, 1'b0, "rank0");
        finish_frame("rank0");
        chk("rank0_const", 32'(u_do), 32'd3);
        send_frame(med_f, 4'd8, 4'd8, 1'b0, "rank8");
        finish_frame("rank8");
        chk("rank8_const", 32'(u_do), 32'd250);
        send_frame(med_f, 4'd15, 4'd15, 1'b0, "rank15");
        finish_frame("rank15");
        chk("rank15_const", 32'(u_do), 32'd250);
        send_frame(med_f, 4'd4, 4'd0, 1'b0, "rankmid");
        finish_frame("rankmid");
        chk("rankmid_const", 32'(u_do), 32'd45);

        // back-to-back
        send_frame(med_f, 4'd4, 4'd4, 1'b0, "b2b1");
        send_frame(f17, 4'd4, 4'd4, 1'b1, "b2b2");
        chk("b2b1_do_const", 32'(last_exp[47:40]), 32'd45);
        finish_frame("b2b2");
        chk("b2b2_do_const", 32'(u_do), 32'd17);

        // abort after 5 samples
        for (int i = 0; i < 5; i++) begin
            dsi = 1'b1; di = 8'($urandom); rank = 4'd4;
            @(posedge clk); #1;
        end
        dsi = 1'b0;
        @(posedge clk); #1;
        chk("abort_u_err", 32'(u_err), 32'd1);
        chk("abort_s_err", 32'(s_err), 32'd1);
        chk("abort_u_dso", 32'(u_dso), 32'd0);
        chk("abort_u_do",  32'(u_do),  32'(last_exp[47:40]));
        chk("abort_u_min", 32'(u_min), 32'(last_exp[39:32]));
        @(posedge clk); #1;
        chk_idle("abort_post");
        send_frame(med_f, 4'd4, 4'd4, 1'b0, "after_abort");
        finish_frame("after_abort");

        // signed
        send_frame(sgn_f, 4'd4, 4'd4, 1'b0, "sgn");
        finish_frame("sgn");
        chk("sgn_do_const",  32'(s_do),  32'h00);
        chk("sgn_min_const", 32'(s_min), 32'h80);
        chk("sgn_max_const", 32'(s_max), 32'h7F);

        // reset mid-frame
        for (int i = 0; i < 4; i++) begin
            dsi = 1'b1; di = 8'($urandom); rank = 4'd4;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("mrst_u_do",  32'(u_do),  32'd0);
        chk("mrst_u_min", 32'(u_min), 32'd0);
        chk("mrst_u_max", 32'(u_max), 32'd0);
        chk("mrst_s_do",  32'(s_do),  32'd0);
        chk_idle("mrst");
        dsi = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_idle("mrst_post");
        chk("mrst_hold_do", 32'(u_do), 32'd0);
        send_frame(med_f, 4'd4, 4'd4, 1'b0, "after_rst");
        finish_frame("after_rst");

        // random frames, random ranks, random idle gaps
        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < 9; i++) rf[i] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 8)] = rf[0];
            r0 = ($urandom_range(0, 1) == 0) ? 4'd4 : 4'($urandom_range(0, 15));
            r1 = 4'($urandom_range(0, 15));
            send_frame(rf, r0, r1, 1'b0, "rnd");
            finish_frame("rnd");
            repeat ($urandom_range(0, 2)) begin
                dsi = 1'b0; di = 8'($urandom);
                @(posedge clk); #1;
                chk_idle("rnd_gap");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
